imem_word_server: RTL and testbench

Word-serial instruction memory that sits directly downstream of the instruction-cache controller and serves its block refills, one word per request. It accepts a word-address read request through a request/busywait handshake and holds it for a programmable latency. It then returns the word with a one-cycle valid pulse. A preload port lets the bench or boot logic fill the array.

---
 rtl/imem_word_server_if.sv | 27 ++
 rtl/imem_word_server.sv | 80 ++++++++
 tb/tb_imem_word_server.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/imem_word_server_if.sv
// imem_word_server_if: request/response and preload signals between a cache controller (master) and the word server (slave)
//   MEM_READ_REQ/MEM_ADDRESS           read request and word address, master -> slave
//   MEM_BUSYWAIT                       request outstanding, slave -> master
//   MEM_READDATA/_VALID/MEM_RESP_ERR   one-cycle response pulse, slave -> master
//   LOAD_EN/LOAD_ADDR/LOAD_DATA        array preload strobe, master -> slave
interface imem_word_server_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  MEM_READ_REQ;
   logic [ADDR_WIDTH-1:0] MEM_ADDRESS;
   logic                  MEM_BUSYWAIT;
   logic [DATA_WIDTH-1:0] MEM_READDATA;
   logic                  MEM_READDATA_VALID;
   logic                  MEM_RESP_ERR;
   logic                  LOAD_EN;
   logic [ADDR_WIDTH-1:0] LOAD_ADDR;
   logic [DATA_WIDTH-1:0] LOAD_DATA;
   modport master (
      output MEM_READ_REQ, MEM_ADDRESS, LOAD_EN, LOAD_ADDR, LOAD_DATA,
      input  MEM_BUSYWAIT, MEM_READDATA, MEM_READDATA_VALID, MEM_RESP_ERR
   );
   modport slave (
      input  MEM_READ_REQ, MEM_ADDRESS, LOAD_EN, LOAD_ADDR, LOAD_DATA,
      output MEM_BUSYWAIT, MEM_READDATA, MEM_READDATA_VALID, MEM_RESP_ERR
   );
endinterface

// File: rtl/imem_word_server.sv
// imem_word_server: word-serial instruction memory serving one word per request after a fixed latency
//   clk    rising-edge clock
//   reset  asynchronous active-low reset; array contents are kept
//   bus    imem_word_server_if slave: request/busywait handshake, registered response, preload port
module imem_word_server #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DATA_WIDTH   = 32,
   parameter int DEPTH_WORDS  = 1024,
   parameter int READ_LATENCY = 4
) (
   input logic                clk,
   input logic                reset,
   imem_word_server_if.slave  bus
);
   localparam int IDX_W = $clog2(DEPTH_WORDS);
   typedef enum logic [1:0] {IDLE, WAIT, RESPOND} state_t;
   state_t                state_q, state_d;
   logic [7:0]            cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];
   logic [DATA_WIDTH-1:0] snap_q, snap_d, rdata_q, rdata_d;
   logic                  serr_q, serr_d, rerr_q, rerr_d;
   logic                  busy_q, busy_d, valid_q, valid_d;
   logic                  accept, addr_err;
   logic                  unused_load_hi;
   assign accept         = bus.MEM_READ_REQ && state_q == IDLE;
   assign addr_err       = (bus.MEM_ADDRESS >> IDX_W) != '0;
   assign unused_load_hi = |(bus.LOAD_ADDR >> IDX_W);
   // The snapshot reads the array before this edge's preload lands, giving read-before-write.
   // The counter covers the WAIT cycles so VALID rises READ_LATENCY edges after the accept edge.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      snap_d  = snap_q;
      serr_d  = serr_q;
      case (state_q)
         IDLE: if (accept) begin
            state_d = WAIT;
            cnt_d   = 8'(READ_LATENCY - 1);
            snap_d  = addr_err ? '0 : mem[bus.MEM_ADDRESS[IDX_W-1:0]];
            serr_d  = addr_err;
         end
         WAIT: begin
            state_d = cnt_q == 8'd0 ? RESPOND : WAIT;
            cnt_d   = cnt_q == 8'd0 ? 8'd0 : cnt_q - 8'd1;
         end
         default: state_d = IDLE;
      endcase
      busy_d  = state_d != IDLE;
      valid_d = state_d == RESPOND;
      rdata_d = valid_d ? snap_d : rdata_q;
      rerr_d  = valid_d && serr_d;
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         snap_q  <= '0;
         serr_q  <= 1'b0;
         rdata_q <= '0;
         rerr_q  <= 1'b0;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         snap_q  <= snap_d;
         serr_q  <= serr_d;
         rdata_q <= rdata_d;
         rerr_q  <= rerr_d;
         busy_q  <= busy_d;
         valid_q <= valid_d;
      end
   end
   always_ff @(posedge clk)
      if (bus.LOAD_EN) mem[bus.LOAD_ADDR[IDX_W-1:0]] <= bus.LOAD_DATA;
   assign bus.MEM_BUSYWAIT       = busy_q;
   assign bus.MEM_READDATA       = rdata_q;
   assign bus.MEM_READDATA_VALID = valid_q;
   assign bus.MEM_RESP_ERR       = rerr_q;
endmodule

// File: tb/tb_imem_word_server.sv
// tb_imem_word_server: directed self-checking bench for imem_word_server with READ_LATENCY=4, DEPTH_WORDS=1024
module tb_imem_word_server;
   logic clk = 1'b0;
   logic reset = 1'b0;
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   imem_word_server_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();
   imem_word_server dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   task automatic tick;
      @(posedge clk);
      #1;
   endtask
   task automatic load(input logic [31:0] a, input logic [31:0] d);
      bus.LOAD_EN = 1'b1;
      bus.LOAD_ADDR = a;
      bus.LOAD_DATA = d;
      tick;
      bus.LOAD_EN = 1'b0;
   endtask
   task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic e, output int vc);
      int n;
      bus.MEM_READ_REQ = 1'b1;
      bus.MEM_ADDRESS = a;
      n = 0;
      do begin tick; n++; end while (!bus.MEM_BUSYWAIT && n < 20);
      chk("accept_timeout", {31'd0, bus.MEM_BUSYWAIT}, 32'd1);
      bus.MEM_READ_REQ = 1'b0;
      n = 0;
      while (!bus.MEM_READDATA_VALID && n < 20) begin tick; n++; end
      chk("valid_timeout", {31'd0, bus.MEM_READDATA_VALID}, 32'd1);
      d = bus.MEM_READDATA;
      e = bus.MEM_RESP_ERR;
      vc = cyc;
   endtask
   initial begin
      logic [31:0] d;
      logic        e;
      int          vc, prev_vc, nvalid;
      bus.MEM_READ_REQ = 1'b0;
      bus.MEM_ADDRESS = '0;
      bus.LOAD_EN = 1'b0;
      bus.LOAD_ADDR = '0;
      bus.LOAD_DATA = '0;
      tick;
      tick;
      chk("rst_busy", {31'd0, bus.MEM_BUSYWAIT}, 32'd0);
      chk("rst_valid", {31'd0, bus.MEM_READDATA_VALID}, 32'd0);
      chk("rst_data", bus.MEM_READDATA, 32'd0);
      chk("rst_err", {31'd0, bus.MEM_RESP_ERR}, 32'd0);
      reset = 1'b1;
      for (int i = 0; i < 4; i++) load(32'h10 + i, 32'hA0 + i);
      load(32'h20, 32'hBAD);
      // exact timing of a single read accepted at edge T
      bus.MEM_READ_REQ = 1'b1;
      bus.MEM_ADDRESS = 32'h10;
      tick;
      bus.MEM_READ_REQ = 1'b0;
      chk("t0_busy", {31'd0, bus.MEM_BUSYWAIT}, 32'd1);
      chk("t0_valid", {31'd0, bus.MEM_READDATA_VALID}, 32'd0);
      for (int i = 1; i < 4; i++) begin
         tick;
         chk("wait_valid", {31'd0, bus.MEM_READDATA_VALID}, 32'd0);
         chk("wait_busy", {31'd0, bus.MEM_BUSYWAIT}, 32'd1);
      end
      tick;
      chk("t4_valid", {31'd0, bus.MEM_READDATA_VALID}, 32'd1);
      chk("t4_data", bus.MEM_READDATA, 32'hA0);
      chk("t4_err", {31'd0, bus.MEM_RESP_ERR}, 32'd0);
      chk("t4_busy", {31'd0, bus.MEM_BUSYWAIT}, 32'd1);
      tick;
      chk("t5_valid", {31'd0, bus.MEM_READDATA_VALID}, 32'd0);
      chk("t5_busy", {31'd0, bus.MEM_BUSYWAIT}, 32'd0);
      chk("t5_hold", bus.MEM_READDATA, 32'hA0);
      // 4-word block refill
      prev_vc = 0;
      for (int i = 0; i < 4; i++) begin
         do_read(32'h10 + i, d, e, vc);
         chk("refill_data", d, 32'hA0 + i);
         chk("refill_err", {31'd0, e}, 32'd0);
         if (i > 0) chk("refill_spacing", {31'd0, vc - prev_vc >= 5}, 32'd1);
         prev_vc = vc;
      end
      tick;
      // requests toggled while busy are ignored
      bus.MEM_READ_REQ = 1'b1;
      bus.MEM_ADDRESS = 32'h11;
      tick;
      bus.MEM_ADDRESS = 32'h20;
      nvalid = 0;
      d = '0;
      for (int i = 0; i < 12; i++) begin
         bus.MEM_READ_REQ = i < 3 ? ~bus.MEM_READ_REQ : 1'b0;
         tick;
         if (bus.MEM_READDATA_VALID) begin nvalid++; d = bus.MEM_READDATA; end
      end
      chk("busy_ignore_count", nvalid, 32'd1);
      chk("busy_ignore_data", d, 32'hA1);
      // out-of-range address, then an in-range one
      do_read(32'h0000_0400, d, e, vc);
      chk("oor_data", d, 32'd0);
      chk("oor_err", {31'd0, e}, 32'd1);
      tick;
      chk("oor_err_pulse", {31'd0, bus.MEM_RESP_ERR}, 32'd0);
      do_read(32'h12, d, e, vc);
      chk("inr_data", d, 32'hA2);
      chk("inr_err", {31'd0, e}, 32'd0);
      tick;
      // same-edge preload and accept: old word returned
      bus.LOAD_EN = 1'b1;
      bus.LOAD_ADDR = 32'h10;
      bus.LOAD_DATA = 32'hFF;
      bus.MEM_READ_REQ = 1'b1;
      bus.MEM_ADDRESS = 32'h10;
      tick;
      bus.LOAD_EN = 1'b0;
      bus.MEM_READ_REQ = 1'b0;
      chk("rbw_accept", {31'd0, bus.MEM_BUSYWAIT}, 32'd1);
      for (int i = 0; i < 4; i++) tick;
      chk("rbw_valid", {31'd0, bus.MEM_READDATA_VALID}, 32'd1);
      chk("rbw_old", bus.MEM_READDATA, 32'hA0);
      tick;
      do_read(32'h10, d, e, vc);
      chk("rbw_new", d, 32'hFF);
      tick;
      // reset two cycles after accept drops the pending read
      bus.MEM_READ_REQ = 1'b1;
      bus.MEM_ADDRESS = 32'h13;
      tick;
      bus.MEM_READ_REQ = 1'b0;
      tick;
      tick;
      #2;
      reset = 1'b0;
      #1;
      chk("arst_busy", {31'd0, bus.MEM_BUSYWAIT}, 32'd0);
      chk("arst_valid", {31'd0, bus.MEM_READDATA_VALID}, 32'd0);
      tick;
      tick;
      reset = 1'b1;
      nvalid = 0;
      for (int i = 0; i < 8; i++) begin
         tick;
         if (bus.MEM_READDATA_VALID) nvalid++;
      end
      chk("arst_no_valid", nvalid, 32'd0);
      do_read(32'h11, d, e, vc);
      chk("arst_preserved", d, 32'hA1);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
